// File: rtl/pc_gen.sv
// Program counter generator: boot vector, sequential fetch advance, trap/redirect
// steering and misaligned-redirect halt with error capture.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000006c),
  parameter bit              C_EXT        = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            compressed_or_not,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic            misalign_err_q, misalign_err_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;

  logic            fetch_accept_c;
  logic            target_misaligned_c;
  logic [XLEN-1:0] pc_step_c;

  // Only RUN presents a valid pc, so acceptance is gated on the state directly.
  assign fetch_accept_c      = (state_q == RUN) && fetch_ready && !stall;
  assign target_misaligned_c = redirect_target[0] || (!C_EXT && redirect_target[1]);
  assign pc_step_c           = (C_EXT && compressed_or_not) ? XLEN'(2) : XLEN'(4);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      default: begin
        // Trap beats redirect beats sequential advance; HALT never accepts fetches.
        if (trap_valid) begin
          pc_d    = {trap_vector[XLEN-1:2], 2'b00};
          state_d = RUN;
        end else if (redirect_valid) begin
          if (target_misaligned_c) begin
            misalign_err_d  = 1'b1;
            misalign_addr_d = redirect_target;
            state_d         = HALT;
          end else begin
            pc_d    = redirect_target;
            state_d = RUN;
          end
        end else if (fetch_accept_c) begin
          pc_d = pc_q + pc_step_c;
        end
      end
    endcase

    pc_valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      pc_valid_q      <= 1'b0;
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pc_valid_q      <= pc_valid_d;
      misalign_err_q  <= misalign_err_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with compressed support, one without,
// sharing stimulus; each phase checks the instance it targets.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h8000006c;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic            fetch_ready;
  logic            compressed_or_not;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;

  logic [XLEN-1:0] pc1, addr1, pc0, addr0;
  logic            val1, err1, val0, err0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .C_EXT(1'b1)) u_dut_c1 (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .compressed_or_not(compressed_or_not), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid),
    .trap_vector(trap_vector), .pc(pc1), .pc_valid(val1),
    .misalign_err(err1), .misalign_addr(addr1)
  );

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .C_EXT(1'b0)) u_dut_c0 (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .compressed_or_not(compressed_or_not), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid),
    .trap_vector(trap_vector), .pc(pc0), .pc_valid(val0),
    .misalign_err(err0), .misalign_addr(addr0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; compressed_or_not = 1'b0;
    redirect_valid = 1'b0; trap_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b1; redirect_target = '0; trap_vector = '0;
    idle();

    // Reset and boot with a 32-bit stream
    tick(); tick();
    check("rst_pc",   pc1,   RV);
    check("rst_val",  32'(val1), 32'd0);
    check("rst_err",  32'(err1), 32'd0);
    check("rst_addr", addr1, 32'h0);
    reset = 1'b0;
    tick();
    check("boot_exit_pc",  pc1, RV);
    check("boot_exit_val", 32'(val1), 32'd1);
    tick(); check("seq_70", pc1, 32'h80000070);
    tick(); check("seq_74", pc1, 32'h80000074);

    // Compressed pattern 1,0,1 then stall
    redirect_valid = 1'b1; redirect_target = 32'h80000100;
    tick(); check("redir_100", pc1, 32'h80000100);
    redirect_valid = 1'b0;
    compressed_or_not = 1'b1; tick(); check("c_102", pc1, 32'h80000102);
    compressed_or_not = 1'b0; tick(); check("c_106", pc1, 32'h80000106);
    compressed_or_not = 1'b1; tick(); check("c_108", pc1, 32'h80000108);
    stall = 1'b1;
    tick(); check("stall1", pc1, 32'h80000108);
    tick(); check("stall2", pc1, 32'h80000108);

    // Trap beats redirect, ignores stall, clears low bits
    compressed_or_not = 1'b0;
    trap_valid = 1'b1; trap_vector = 32'h80000203;
    redirect_valid = 1'b1; redirect_target = 32'h80000400;
    tick();
    check("trap_pc",  pc1, 32'h80000200);
    check("trap_val", 32'(val1), 32'd1);
    idle();

    // Misaligned redirect halts; HALT ignores fetch and compressed
    redirect_valid = 1'b1; redirect_target = 32'h80000401;
    tick();
    check("mis_err",  32'(err1), 32'd1);
    check("mis_addr", addr1, 32'h80000401);
    check("mis_val",  32'(val1), 32'd0);
    check("mis_pc",   pc1, 32'h80000200);
    redirect_valid = 1'b0; compressed_or_not = 1'b1;
    tick();
    check("halt_err_pulse", 32'(err1), 32'd0);
    check("halt_pc_hold",   pc1, 32'h80000200);
    check("halt_addr_hold", addr1, 32'h80000401);
    compressed_or_not = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h80000403;
    tick();
    check("halt_repulse", 32'(err1), 32'd1);
    check("halt_readdr",  addr1, 32'h80000403);
    check("halt_stay",    32'(val1), 32'd0);
    redirect_target = 32'h80000400;
    tick();
    check("halt_exit_pc",  pc1, 32'h80000400);
    check("halt_exit_val", 32'(val1), 32'd1);
    check("halt_exit_err", 32'(err1), 32'd0);

    // Trap exits HALT as well
    redirect_target = 32'h80000005;
    tick();
    check("halt2_val", 32'(val1), 32'd0);
    redirect_valid = 1'b0; trap_valid = 1'b1; trap_vector = 32'h80000302;
    tick();
    check("trap_exit_pc",  pc1, 32'h80000300);
    check("trap_exit_val", 32'(val1), 32'd1);
    idle();

    // Wraparound at top of address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
    tick(); check("wrap_pre", pc1, 32'hFFFFFFFC);
    redirect_valid = 1'b0;
    tick(); check("wrap_zero", pc1, 32'h00000000);

    // Reset while halted
    redirect_valid = 1'b1; redirect_target = 32'h00000011;
    tick(); check("halt3_err", 32'(err1), 32'd1);
    reset = 1'b1; redirect_target = 32'h00000100;
    tick();
    check("hrst_pc",   pc1, RV);
    check("hrst_val",  32'(val1), 32'd0);
    check("hrst_err",  32'(err1), 32'd0);
    check("hrst_addr", addr1, 32'h0);

    // Trap and redirect during BOOT are ignored
    reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h80000500;
    trap_valid = 1'b1; trap_vector = 32'h80000600;
    tick();
    check("boot_ign_pc",  pc1, RV);
    check("boot_ign_val", 32'(val1), 32'd1);
    idle();

    // No compressed support: bit-1 misalignment and forced +4
    reset = 1'b1;
    tick();
    check("c0_rst_pc", pc0, RV);
    reset = 1'b0;
    tick(); check("c0_boot_pc", pc0, RV);
    redirect_valid = 1'b1; redirect_target = 32'h80000402;
    tick();
    check("c0_mis_err",  32'(err0), 32'd1);
    check("c0_mis_addr", addr0, 32'h80000402);
    check("c0_mis_val",  32'(val0), 32'd0);
    check("c0_mis_pc",   pc0, RV);
    redirect_target = 32'h80000400;
    tick(); check("c0_redir", pc0, 32'h80000400);
    redirect_valid = 1'b0; compressed_or_not = 1'b1;
    tick(); check("c0_plus4", pc0, 32'h80000404);
    tick(); check("c0_plus4b", pc0, 32'h80000408);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
